// File: rtl/dm_sized_if.sv
// Request/response bundle between the MEM stage and the byte-addressed data memory.
interface dm_sized_if;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic        busy;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        misalign;
  logic        oob;

  modport master (
    output addr, data_in, MemWrite, MemRead, size, unsigned_ld,
    input  busy, data_out, rd_valid, misalign, oob
  );

  modport slave (
    input  addr, data_in, MemWrite, MemRead, size, unsigned_ld,
    output busy, data_out, rd_valid, misalign, oob
  );
endinterface

// File: rtl/dm_sized.sv
// Byte-addressed data memory with sized stores/loads, error flags and a
// post-reset clear sequencer.
//   state   | meaning
//   S_INIT  | clearing words (or one idle cycle when clearing is disabled); busy=1
//   S_READY | serving one request per cycle
module dm_sized #(
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic        clk,
  input logic        reset,
  dm_sized_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            busy_q;
  logic [31:0]     data_out_q;
  logic            rd_valid_q;
  logic            misalign_q;
  logic            oob_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   widx_d;
  logic [1:0]      lane_d;
  logic            mis_d;
  logic            oob_d;
  logic            err_d;
  logic            req_d;
  logic            st_we_d;
  logic            ld_d;
  logic            clr_we_d;
  logic [3:0]      wmask_d;
  logic [31:0]     wdata_d;
  logic [31:0]     word_rd_d;
  logic [7:0]      byte_sel_d;
  logic [15:0]     half_sel_d;
  logic [31:0]     ld_val_d;

  assign widx_d = bus.addr[AW+1:2];
  assign lane_d = bus.addr[1:0];
  assign mis_d  = (bus.size == 2'b11)
                | ((bus.size == 2'b01) & bus.addr[0])
                | ((bus.size == 2'b10) & (|bus.addr[1:0]));
  assign oob_d  = |bus.addr[31:AW+2];
  assign err_d  = mis_d | oob_d;

  assign req_d    = (state_q == S_READY) & (bus.MemWrite | bus.MemRead);
  assign st_we_d  = (state_q == S_READY) & bus.MemWrite & ~err_d;
  assign ld_d     = (state_q == S_READY) & bus.MemRead & ~bus.MemWrite;
  assign clr_we_d = (state_q == S_INIT) & CLEAR_ON_RESET;

  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = bus.data_in;
    case (bus.size)
      2'b00: begin
        wmask_d = 4'b0001 << lane_d;
        wdata_d = {4{bus.data_in[7:0]}};
      end
      2'b01: begin
        wmask_d = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.data_in[15:0]}};
      end
      2'b10:   wmask_d = 4'b1111;
      default: wmask_d = 4'b0000;
    endcase
  end

  assign word_rd_d  = mem_q[widx_d];
  assign byte_sel_d = word_rd_d[{lane_d, 3'b000} +: 8];
  assign half_sel_d = bus.addr[1] ? word_rd_d[31:16] : word_rd_d[15:0];

  always_comb begin
    case (bus.size)
      2'b00:   ld_val_d = {{24{~bus.unsigned_ld & byte_sel_d[7]}}, byte_sel_d};
      2'b01:   ld_val_d = {{16{~bus.unsigned_ld & half_sel_d[15]}}, half_sel_d};
      default: ld_val_d = word_rd_d;
    endcase
  end

  // Storage has no reset; the INIT sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we_d) begin
        mem_q[cnt_q] <= '0;
      end else if (st_we_d) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_d[b]) mem_q[widx_d][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (CLEAR_ON_RESET) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
              state_q <= S_READY;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
          end
        end
        S_READY: begin
          if (req_d) begin
            misalign_q <= mis_d;
            oob_q      <= oob_d;
          end
          if (ld_d) begin
            rd_valid_q <= 1'b1;
            data_out_q <= err_d ? 32'h0 : ld_val_d;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.misalign = misalign_q;
  assign bus.oob      = oob_q;
endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: byte-array reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_dm_sized;
  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dm_sized_if bus();

  dm_sized #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, busy as a cycles-remaining count.
  logic [7:0]  mb [NBYTES];
  int          init_left;
  logic        e_busy, e_rv, e_mis, e_oob;
  logic [31:0] e_dout;
  int          m_nb, m_a;
  logic        m_err;
  logic [31:0] m_v;

  always @(posedge clk) begin
    if (reset) begin
      init_left = DEPTH;
      e_busy = 1'b1; e_dout = '0; e_rv = 1'b0; e_mis = 1'b0; e_oob = 1'b0;
    end else begin
      e_rv = 1'b0; e_mis = 1'b0; e_oob = 1'b0;
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) begin
          for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
          e_busy = 1'b0;
        end
      end else if (bus.MemWrite || bus.MemRead) begin
        m_nb  = (bus.size == 2'd0) ? 1 : (bus.size == 2'd1) ? 2 : 4;
        e_mis = (bus.size == 2'd3) || ((bus.addr % m_nb) != 0);
        e_oob = bus.addr >= NBYTES;
        m_err = e_mis || e_oob;
        m_a   = int'(bus.addr % NBYTES);
        if (bus.MemWrite) begin
          if (!m_err)
            for (int i = 0; i < m_nb; i++) mb[m_a + i] = bus.data_in[8*i +: 8];
        end else begin
          e_rv = 1'b1;
          if (m_err) e_dout = '0;
          else begin
            m_v = '0;
            for (int i = 0; i < m_nb; i++) m_v = m_v | (32'(mb[m_a + i]) << (8*i));
            if (!bus.unsigned_ld && m_v[8*m_nb-1] && m_nb < 4) m_v = m_v | (32'hFFFF_FFFF << (8*m_nb));
            e_dout = m_v;
          end
        end
      end
    end
    #1;
    chk("busy", {31'b0, bus.busy}, {31'b0, e_busy});
    chk("data_out", bus.data_out, e_dout);
    chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, e_rv});
    chk("misalign", {31'b0, bus.misalign}, {31'b0, e_mis});
    chk("oob", {31'b0, bus.oob}, {31'b0, e_oob});
  end

  task automatic idle();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.size = 2'd2;
    bus.unsigned_ld = 1'b0; bus.addr = '0; bus.data_in = '0;
  endtask

  // Drive one request for one cycle (called at a negedge), return at the next negedge.
  task automatic req(input logic we, input logic re, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite = we; bus.MemRead = re; bus.size = sz;
    bus.unsigned_ld = uns; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  int nb;

  initial begin
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // A word load held during the clear must never produce rd_valid.
    bus.MemRead = 1'b1; bus.addr = 32'h0; bus.size = 2'd2;
    count_busy(nb);
    idle();
    chk("busy_cycles", nb, 16);

    req(0, 1, 2'd2, 0, 32'h3C, 0);
    chk("lit_ld3c_rv", {31'b0, bus.rd_valid}, 32'd1);
    chk("lit_ld3c", bus.data_out, 32'h0);

    req(1, 0, 2'd2, 0, 32'h8, 32'h11223344);
    req(1, 0, 2'd0, 0, 32'h9, 32'h000000AA);
    req(0, 1, 2'd2, 0, 32'h8, 0);
    chk("lit_merge", bus.data_out, 32'h1122AA44);

    req(1, 0, 2'd2, 0, 32'h0, 32'h80FF7F01);
    req(0, 1, 2'd0, 0, 32'h2, 0);
    chk("lit_lb_s", bus.data_out, 32'hFFFFFFFF);
    req(0, 1, 2'd0, 1, 32'h3, 0);
    chk("lit_lb_u", bus.data_out, 32'h00000080);
    req(0, 1, 2'd1, 0, 32'h2, 0);
    chk("lit_lh_s", bus.data_out, 32'hFFFF80FF);
    req(0, 1, 2'd1, 1, 32'h0, 0);
    chk("lit_lh_u", bus.data_out, 32'h00007F01);

    req(1, 0, 2'd2, 0, 32'h4, 32'hCAFEF00D);
    req(1, 0, 2'd1, 0, 32'h5, 32'h0000BEEF);
    chk("lit_mis_sh", {31'b0, bus.misalign}, 32'd1);
    @(negedge clk);
    chk("lit_mis_pulse", {31'b0, bus.misalign}, 32'd0);
    req(0, 1, 2'd2, 0, 32'h4, 0);
    chk("lit_mis_nomod", bus.data_out, 32'hCAFEF00D);
    req(0, 1, 2'd2, 0, 32'h6, 0);
    chk("lit_mis_ld", {bus.data_out[30:0], bus.rd_valid & bus.misalign}, 32'h1);
    req(0, 1, 2'd3, 0, 32'h0, 0);
    chk("lit_sz11", {31'b0, bus.misalign}, 32'd1);

    req(1, 0, 2'd2, 0, 32'h1000, 32'hDEADBEEF);
    chk("lit_oob", {31'b0, bus.oob}, 32'd1);
    req(0, 1, 2'd2, 0, 32'h0, 0);
    chk("lit_oob_nomod", bus.data_out, 32'h80FF7F01);
    req(1, 1, 2'd2, 0, 32'h4, 32'h5A5A5A5A);
    chk("lit_wr_rd_rv", {31'b0, bus.rd_valid}, 32'd0);
    req(0, 1, 2'd2, 0, 32'h4, 0);
    chk("lit_wr_rd", bus.data_out, 32'h5A5A5A5A);

    // Reset again, then interrupt the clear at its fifth cycle.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    count_busy(nb);
    chk("busy_restart", nb, 16);

    for (int c = 0; c < 3000; c++) begin
      bus.MemWrite    = ($urandom_range(0, 2) == 0);
      bus.MemRead     = ($urandom_range(0, 1) == 0);
      bus.size        = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      bus.unsigned_ld = 1'($urandom_range(0, 1));
      bus.data_in     = $urandom;
      case ($urandom_range(0, 19))
        0:       bus.addr = 32'h1000;
        1:       bus.addr = $urandom;
        default: bus.addr = 32'($urandom_range(0, NBYTES + 7));
      endcase
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
